// File: rtl/morse_letter_sender_pkg.sv
// Shared types and constants for the Morse letter sender.
// Holds FSM encodings, width defaults and the A-H pattern table.
package morse_letter_sender_pkg;

  localparam int DEF_PATTERN_W = 12;
  localparam int DEF_LEN_W     = 4;
  localparam int CODE_W        = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    SEND = 2'd2
  } state_t;

  // Patterns are MSB-first, left-aligned in CODE_W bits
  localparam logic [CODE_W-1:0] CODE_A = 11'b10111000000;
  localparam logic [CODE_W-1:0] CODE_B = 11'b11101010100;
  localparam logic [CODE_W-1:0] CODE_C = 11'b11101011101;
  localparam logic [CODE_W-1:0] CODE_D = 11'b11101010000;
  localparam logic [CODE_W-1:0] CODE_E = 11'b10000000000;
  localparam logic [CODE_W-1:0] CODE_F = 11'b10101110100;
  localparam logic [CODE_W-1:0] CODE_G = 11'b11101110100;
  localparam logic [CODE_W-1:0] CODE_H = 11'b10101010000;

  localparam logic [3:0] LEN_A = 4'd5;
  localparam logic [3:0] LEN_B = 4'd9;
  localparam logic [3:0] LEN_C = 4'd11;
  localparam logic [3:0] LEN_D = 4'd7;
  localparam logic [3:0] LEN_E = 4'd1;
  localparam logic [3:0] LEN_F = 4'd9;
  localparam logic [3:0] LEN_G = 4'd9;
  localparam logic [3:0] LEN_H = 4'd7;

endpackage

// File: rtl/morse_lut.sv
// Letter (0=A..7=H) to left-aligned Morse pattern and slot count.
// Purely combinational; shared with later letter/display blocks.
module morse_lut
  import morse_letter_sender_pkg::*;
#(
  parameter int PATTERN_W = DEF_PATTERN_W,
  parameter int LEN_W     = DEF_LEN_W
) (
  input  logic [2:0]           letter,
  output logic [PATTERN_W-1:0] pattern,
  output logic [LEN_W-1:0]     length
);

  logic [CODE_W-1:0] code;
  logic [3:0]        len;

  always_comb begin
    code = '0;
    len  = '0;
    unique case (letter)
      3'd0: begin code = CODE_A; len = LEN_A; end
      3'd1: begin code = CODE_B; len = LEN_B; end
      3'd2: begin code = CODE_C; len = LEN_C; end
      3'd3: begin code = CODE_D; len = LEN_D; end
      3'd4: begin code = CODE_E; len = LEN_E; end
      3'd5: begin code = CODE_F; len = LEN_F; end
      3'd6: begin code = CODE_G; len = LEN_G; end
      3'd7: begin code = CODE_H; len = LEN_H; end
    endcase
    // Widen then left-align into the shift register width
    pattern = PATTERN_W'(code) << (PATTERN_W - CODE_W);
    length  = LEN_W'(len);
  end

endmodule

// File: rtl/morse_letter_sender.sv
// Sends one Morse letter serially on LedOut, one symbol slot per Tick.
// Start is edge-triggered; ARM aligns the first slot to a full Tick period.
module morse_letter_sender
  import morse_letter_sender_pkg::*;
#(
  parameter int PATTERN_W = DEF_PATTERN_W,
  parameter int LEN_W     = DEF_LEN_W
) (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic       Tick,
  input  logic       Start,
  input  logic [2:0] Letter,
  output logic       LedOut,
  output logic       Busy
);

  state_t               state_q, state_d;
  logic [2:0]           letter_q, letter_d;
  logic [PATTERN_W-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic                 led_q, led_d;
  logic                 busy_q, busy_d;
  logic                 start_q;
  logic                 start_rise;

  logic [PATTERN_W-1:0] lut_pat;
  logic [LEN_W-1:0]     lut_len;

  morse_lut #(
    .PATTERN_W(PATTERN_W),
    .LEN_W    (LEN_W)
  ) u_lut (
    .letter (letter_q),
    .pattern(lut_pat),
    .length (lut_len)
  );

  assign start_rise = Start & ~start_q;

  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      letter_q <= '0;
      shreg_q  <= '0;
      cnt_q    <= '0;
      led_q    <= 1'b0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      letter_q <= letter_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
      start_q  <= Start;
    end
  end

  always_comb begin
    state_d  = state_q;
    letter_d = letter_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    led_d    = led_q;
    busy_d   = busy_q;
    unique case (state_q)
      IDLE: begin
        led_d  = 1'b0;
        busy_d = 1'b0;
        if (start_rise) begin
          letter_d = Letter;
          busy_d   = 1'b1;
          state_d  = ARM;
        end
      end
      ARM: begin
        if (Tick) begin
          shreg_d = lut_pat;
          cnt_d   = lut_len;
          led_d   = lut_pat[PATTERN_W-1];
          state_d = SEND;
        end
      end
      SEND: begin
        if (Tick) begin
          if (cnt_q == LEN_W'(1)) begin
            shreg_d = '0;
            cnt_d   = '0;
            led_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            shreg_d = shreg_q << 1;
            cnt_d   = cnt_q - LEN_W'(1);
            led_d   = shreg_q[PATTERN_W-2];
          end
        end
      end
      default: begin
        led_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign LedOut = led_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_morse_letter_sender.sv
// Randomized and directed bench for morse_letter_sender.
// Reference model expands dot/dash strings into a slot queue.
module tb_morse_letter_sender;

  logic       ClockIn = 1'b0;
  logic       Reset   = 1'b1;
  logic       Tick    = 1'b0;
  logic       Start   = 1'b0;
  logic [2:0] Letter  = 3'd0;
  logic       LedOut;
  logic       Busy;

  int errs   = 0;
  int checks = 0;

  morse_letter_sender dut (
    .ClockIn(ClockIn),
    .Reset  (Reset),
    .Tick   (Tick),
    .Start  (Start),
    .Letter (Letter),
    .LedOut (LedOut),
    .Busy   (Busy)
  );

  always #5 ClockIn = ~ClockIn;

  string morse [8] = '{".-", "-...", "-.-.", "-..",
                       ".", "..-.", "--.", "...."};

  // Reference model state
  bit       mq[$];
  bit       m_led, m_busy, m_arm, m_sq;
  bit [2:0] m_letter;
  int       tick_n;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
               $time);
    end
  endtask

  function automatic void expand(input string s);
    mq.delete();
    for (int i = 0; i < s.len(); i++) begin
      if (i > 0) mq.push_back(1'b0);
      if (s[i] == "-") begin
        repeat (3) mq.push_back(1'b1);
      end else begin
        mq.push_back(1'b1);
      end
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_led = 0; m_busy = 0; m_arm = 0; m_sq = 0; m_letter = 0;
  endfunction

  // Advance the model across one rising edge using current inputs
  function automatic void model_edge();
    bit rise;
    rise = Start && !m_sq;
    m_sq = Start;
    if (!m_busy) begin
      if (rise) begin
        m_busy = 1; m_arm = 1; m_letter = Letter;
      end
    end else if (Tick) begin
      if (m_arm) begin
        m_arm = 0;
        expand(morse[m_letter]);
        m_led = mq.pop_front();
      end else if (mq.size() == 0) begin
        m_busy = 0; m_led = 0;
      end else begin
        m_led = mq.pop_front();
      end
    end
  endfunction

  task automatic step(input logic s, input logic [2:0] l, input logic t);
    @(negedge ClockIn);
    chk("led", LedOut, m_led);
    chk("busy", Busy, m_busy);
    Start = s; Letter = l; Tick = t;
    model_edge();
  endtask

  // Periodic Tick every 4 clocks
  task automatic pstep(input logic s, input logic [2:0] l);
    step(s, l, (tick_n % 4) == 3);
    tick_n++;
  endtask

  task automatic send_letter(input logic [2:0] l, input int cycles);
    pstep(1'b1, l);
    for (int i = 0; i < cycles; i++) pstep(1'b0, l);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_busy && n < 200) begin
      pstep(1'b0, 3'd0);
      n++;
    end
    chk("idle_timeout", 32'(n < 200), 32'd1);
  endtask

  initial begin
    model_reset();
    tick_n = 0;
    repeat (2) @(negedge ClockIn);
    chk("rst_led", LedOut, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    Reset = 1'b0;

    // Tick in IDLE must do nothing
    repeat (8) pstep(1'b0, 3'd4);

    // E, A, C
    send_letter(3'd4, 12);
    wait_idle();
    send_letter(3'd0, 30);
    wait_idle();
    send_letter(3'd2, 60);
    wait_idle();

    // B with mid-send Start edge and Letter change
    pstep(1'b1, 3'd1);
    repeat (10) pstep(1'b0, 3'd1);
    pstep(1'b1, 3'd7);
    repeat (5) pstep(1'b1, 3'd2);
    repeat (5) pstep(1'b0, 3'd6);
    wait_idle();

    // Start held high across completion
    pstep(1'b1, 3'd4);
    repeat (30) pstep(1'b1, 3'd4);
    chk("held_idle", Busy, 1'b0);
    repeat (4) pstep(1'b0, 3'd4);

    // Start rise coincident with Tick in IDLE
    while ((tick_n % 4) != 3) pstep(1'b0, 3'd0);
    pstep(1'b1, 3'd0);
    repeat (30) pstep(1'b0, 3'd0);
    wait_idle();

    // Reset mid-send while the LED is on
    send_letter(3'd2, 0);
    begin
      int n;
      n = 0;
      while (!m_led && n < 100) begin
        pstep(1'b0, 3'd2);
        n++;
      end
      chk("led_on_timeout", 32'(m_led), 32'd1);
    end
    #2 Reset = 1'b1;
    #1;
    chk("async_led", LedOut, 1'b0);
    chk("async_busy", Busy, 1'b0);
    model_reset();
    Start = 1'b0;
    @(negedge ClockIn);
    Reset = 1'b0;
    repeat (12) pstep(1'b0, 3'd5);
    send_letter(3'd6, 50);
    wait_idle();

    // Random stimulus
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(0, 3) == 0), 3'($urandom),
           1'($urandom_range(0, 2) == 0));
    end
    for (int i = 0; i < 200; i++) step(1'b0, 3'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/morse_letter_sender.md
Name: morse_letter_sender

Overview:
- Downstream consumer of the rate-divider enable pulse.
- Takes a one-of-eight letter selection (A–H) and a start request.
- Emits the letter's Morse pattern serially on a single LED output, one symbol slot per Tick.
- At the board level, Tick comes from the existing rate divider set to 0.5 s. Letter comes from SW[2:0], Start from an inverted KEY, and LedOut drives LEDR[0].

Parameters:
- PATTERN_W, 12, width of the pattern shift register. Must be at least 11, the longest pattern.
- LEN_W, 4, width of the remaining-symbol counter. Must satisfy 2^LEN_W > PATTERN_W.

Ports:
- ClockIn  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- Tick  in  1  one-cycle enable pulse from the rate divider; marks symbol-slot boundaries
- Start  in  1  send request; synchronous to ClockIn; acted on at its rising edge only
- Letter  in  3  0=A … 7=H; sampled at the accepted Start edge
- LedOut  out  1  serial Morse output; 1 = LED on
- Busy  out  1  high from an accepted Start until the last symbol slot ends

Behaviour:
- Encoding: 1 = on for one slot, 0 = off for one slot.
  - Dot = "1", dash = "111", intra-letter gap = "0". No trailing gap.
  - Patterns are MSB-first and left-aligned in PATTERN_W bits, zero-padded.
- Letter table (letter: bits, length):
  - A: 10111, 5
  - B: 111010101, 9
  - C: 11101011101, 11
  - D: 1110101, 7
  - E: 1, 1
  - F: 101011101, 9
  - G: 111011101, 9
  - H: 1010101, 7
- Reset (async, any state): state=IDLE, LedOut=0, Busy=0, shift register=0, counter=0, start-edge register=0.
- Start edge: start_rise = Start & ~start_q, where start_q is Start registered every cycle.
- FSM states: IDLE, ARM, SEND.
- IDLE:
  - LedOut=0, Busy=0.
  - start_rise → latch Letter into letter_q, go to ARM, Busy=1 next cycle.
  - Start held high does not retrigger.
  - Tick is ignored in IDLE.
- ARM:
  - Waits for the next slot boundary, so the first symbol lasts exactly one full Tick period.
  - Tick → load shreg=pattern(letter_q), cnt=length(letter_q), LedOut<=pattern MSB, go to SEND.
  - LedOut changes in the cycle after the Tick.
- SEND, on Tick:
  - cnt==1: go to IDLE; LedOut<=0 and Busy<=0 in the same edge.
  - Otherwise: shreg<<=1 (zero fill), cnt<=cnt-1, LedOut<=new MSB.
  - Cycles without Tick hold all state.
- Busy spans exactly 1 + length Tick boundaries after the accepted edge:
  - ARM lasts until the first Tick.
  - SEND covers length slots.
- Simultaneous events:
  - start_rise and Tick in the same IDLE cycle → enter ARM only. That Tick is not consumed as a boundary.
  - start_rise while Busy → ignored, not queued.
  - Letter changes while Busy → no effect.
- Reset mid-send: LedOut drops to 0 immediately (async); the next send starts clean.
- No arithmetic overflow is possible: cnt never decrements below 1 in SEND.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package/header holds:
  - state encodings: IDLE=2'd0, ARM=2'd1, SEND=2'd2
  - PATTERN_W and LEN_W defaults
  - the eight pattern/length constants
- Sub-module morse_lut: purely combinational, Letter[2:0] → {pattern[PATTERN_W-1:0], length[LEN_W-1:0]}. Reusable by later letter/display blocks.
- Top-level board wrapper (separate file) instantiates the RateDivider (Speed fixed to 0.5 s equivalent), morse_letter_sender, and the LED hookup. It is not part of this block.

Test Plan:
- Reset: Reset=1 mid-run with LedOut=1 → LedOut=0 and Busy=0 within the same cycle; no activity until a new Start edge.
- Send E: Tick every 4 clocks, Letter=4, Start pulse → Busy high; LedOut=1 for exactly one Tick period after the first Tick; then LedOut=0 and Busy=0 at the second Tick.
- Send A: Letter=0 → LedOut per slot 1,0,1,1,1, each slot 4 clocks; Busy deasserts at the 6th Tick after Start.
- Send C (longest): Letter=2 → 11 slots 1,1,1,0,1,0,1,1,1,0,1; cnt reaches 1 without wrap; the FSM returns to IDLE.
- Re-trigger and hold:
  - A second Start edge and a Letter change mid-send of B → the output matches B exactly.
  - Start held high across completion → no second send.
- Coincident Start and Tick in IDLE → ARM entered; the first symbol appears only after the following Tick. Checked against a Tick at the same edge as the Start rise.
